// File: rtl/prim_util_pkg.sv
// rtl/prim_util_pkg.sv - shared sizing helpers for the prim FIFO family
//
// Purpose: width helpers used to size pointers and counters.
// Ports:   none (package).

package prim_util_pkg;

   // Bits needed to hold values 0..value-1, never less than one bit so that
   // single-entry structures still get a legal vector.
   function automatic int vbits(input int value);
      return (value <= 1) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/prim_fifo_sync_cnt.sv
// rtl/prim_fifo_sync_cnt.sv - wrap-aware write/read pointer pair for sync FIFOs
//
// Purpose: two pointers of vbits(Depth) value bits plus a wrap bit. The value
//          counts 0..Depth-1 and toggles the wrap bit when it rolls over, so
//          non-power-of-2 depths distinguish full from empty.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clr_i           synchronous flush, wins over increments
//   incr_wptr_i     advance write pointer
//   incr_rptr_i     advance read pointer
//   wptr_o, rptr_o  {wrap, value} pointers
//   err_o           a pointer value left the 0..Depth-1 range

module prim_fifo_sync_cnt
   import prim_util_pkg::*;
#(
   parameter int Depth = 4,
   localparam int PtrW = vbits(Depth) + 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            clr_i,
   input  logic            incr_wptr_i,
   input  logic            incr_rptr_i,
   output logic [PtrW-1:0] wptr_o,
   output logic [PtrW-1:0] rptr_o,
   output logic            err_o
);

   localparam int PtrvW = PtrW - 1;
   localparam logic [PtrvW-1:0] LastV = PtrvW'(Depth - 1);

   logic [PtrW-1:0] wptr_q, rptr_q;

   // The value stays below Depth-1 on the increment path, so +1 never
   // carries into the wrap bit.
   function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] ptr);
      if (ptr[PtrvW-1:0] == LastV) begin
         return {~ptr[PtrW-1], {PtrvW{1'b0}}};
      end
      return ptr + PtrW'(1);
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else if (clr_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (incr_wptr_i) wptr_q <= ptr_next(wptr_q);
         if (incr_rptr_i) rptr_q <= ptr_next(rptr_q);
      end
   end

   assign wptr_o = wptr_q;
   assign rptr_o = rptr_q;
   assign err_o  = (wptr_q[PtrvW-1:0] > LastV) | (rptr_q[PtrvW-1:0] > LastV);

endmodule

// File: rtl/prim_fifo_sync_wm.sv
// rtl/prim_fifo_sync_wm.sv - sync FIFO with watermarks, crossing pulse and drop accounting
//
// Purpose: arbitrary-depth synchronous FIFO for peripheral RX/TX queues with
//          software thresholds and a saturating count of rejected writes.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clr_i                synchronous flush (highest priority)
//   wvalid_i/wready_o    write handshake, wdata_i write data
//   rvalid_o/rready_i    read handshake, rdata_o read data
//   full_o, depth_o      occupancy
//   af_thresh_i          almost-full threshold (0 disables)
//   ae_thresh_i          almost-empty threshold
//   almost_full_o        registered depth_o >= af_thresh_i
//   almost_empty_o       registered depth_o <= ae_thresh_i
//   af_rise_o            one-cycle pulse on almost_full_o rising
//   drop_cnt_o, ovf_o    saturating rejected-write count, sticky overflow flag

module prim_fifo_sync_wm
   import prim_util_pkg::*;
#(
   parameter int Width             = 16,
   parameter int Depth             = 4,
   parameter bit Pass              = 1'b1,
   parameter bit OutputZeroIfEmpty = 1'b1,
   parameter int CntW              = 8,
   localparam int DepthW           = vbits(Depth + 1)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clr_i,
   input  logic              wvalid_i,
   output logic              wready_o,
   input  logic [Width-1:0]  wdata_i,
   output logic              rvalid_o,
   input  logic              rready_i,
   output logic [Width-1:0]  rdata_o,
   output logic              full_o,
   output logic [DepthW-1:0] depth_o,
   input  logic [DepthW-1:0] af_thresh_i,
   input  logic [DepthW-1:0] ae_thresh_i,
   output logic              almost_full_o,
   output logic              almost_empty_o,
   output logic              af_rise_o,
   output logic [CntW-1:0]   drop_cnt_o,
   output logic              ovf_o
);

   localparam int PtrvW = vbits(Depth);
   localparam int PtrW  = PtrvW + 1;
   localparam logic [DepthW-1:0] DepthFull = DepthW'(Depth);

   // Held high by reset and for the first cycle after release so that no
   // handshake happens while the rest of the system is still coming up.
   logic under_rst_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) under_rst_q <= 1'b1;
      else         under_rst_q <= 1'b0;
   end

   logic [PtrW-1:0] wptr, rptr;
   logic            incr_w, incr_r, cnt_err_unused;

   prim_fifo_sync_cnt #(.Depth(Depth)) u_cnt (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clr_i       (clr_i),
      .incr_wptr_i (incr_w),
      .incr_rptr_i (incr_r),
      .wptr_o      (wptr),
      .rptr_o      (rptr),
      .err_o       (cnt_err_unused)
   );

   logic empty, full, pass_through, wr_en, rd_en, drop;

   assign empty = (wptr == rptr);
   assign full  = (wptr[PtrvW-1:0] == rptr[PtrvW-1:0]) && (wptr[PtrW-1] != rptr[PtrW-1]);

   // An empty FIFO with Pass set presents the incoming word directly. If it
   // is read that cycle both pointers advance together, so depth stays 0.
   assign pass_through = Pass & empty & wvalid_i;

   assign wready_o = ~full & ~under_rst_q;
   assign rvalid_o = (~empty | pass_through) & ~under_rst_q;
   assign wr_en    = wvalid_i & wready_o;
   assign rd_en    = rvalid_o & rready_i;
   assign incr_w   = wr_en & ~clr_i;
   assign incr_r   = rd_en & ~clr_i;
   assign drop     = wvalid_i & ~wready_o & ~under_rst_q;
   assign full_o   = full;

   // Storage carries no reset; only pointers define what is valid.
   logic [Width-1:0] mem_rdata;
   if (Depth == 1) begin : g_single
      logic [Width-1:0] mem_q;
      always_ff @(posedge clk_i) begin
         if (incr_w) mem_q <= wdata_i;
      end
      assign mem_rdata = mem_q;
   end else begin : g_multi
      logic [Width-1:0] mem_q [Depth];
      always_ff @(posedge clk_i) begin
         if (incr_w) mem_q[wptr[PtrvW-1:0]] <= wdata_i;
      end
      assign mem_rdata = mem_q[rptr[PtrvW-1:0]];
   end

   logic [Width-1:0] rdata_raw;
   assign rdata_raw = pass_through ? wdata_i : mem_rdata;
   assign rdata_o   = (OutputZeroIfEmpty && !rvalid_o) ? '0 : rdata_raw;

   // Occupancy from the pointer pair; a lower write value means the write
   // pointer has wrapped once more than the read pointer.
   function automatic logic [DepthW-1:0] ptr_depth(input logic [PtrW-1:0] w,
                                                   input logic [PtrW-1:0] r);
      logic [PtrvW-1:0] wv, rv;
      wv = w[PtrvW-1:0];
      rv = r[PtrvW-1:0];
      if (wv == rv)     return (w[PtrW-1] != r[PtrW-1]) ? DepthFull : '0;
      else if (wv > rv) return DepthW'(wv - rv);
      else              return DepthW'(Depth - int'(rv) + int'(wv));
   endfunction

   assign depth_o = ptr_depth(wptr, rptr);

   // Watermarks are registered from the occupancy the next edge produces,
   // so they change on the same edge as depth_o.
   logic [DepthW-1:0] depth_next;
   always_comb begin
      depth_next = depth_o;
      if (clr_i)                   depth_next = '0;
      else if (incr_w && !incr_r)  depth_next = depth_o + DepthW'(1);
      else if (!incr_w && incr_r)  depth_next = depth_o - DepthW'(1);
   end

   logic af_q, af_d_q, ae_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         af_q   <= 1'b0;
         af_d_q <= 1'b0;
         ae_q   <= 1'b1;
      end else begin
         af_q   <= (af_thresh_i != '0) && (depth_next >= af_thresh_i);
         ae_q   <= (depth_next <= ae_thresh_i);
         af_d_q <= af_q;
      end
   end

   assign almost_full_o  = af_q;
   assign almost_empty_o = ae_q;
   assign af_rise_o      = af_q & ~af_d_q;

   logic [CntW-1:0] drop_cnt_q;
   logic            ovf_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         drop_cnt_q <= '0;
         ovf_q      <= 1'b0;
      end else if (clr_i) begin
         drop_cnt_q <= '0;
         ovf_q      <= 1'b0;
      end else if (drop) begin
         ovf_q <= 1'b1;
         if (drop_cnt_q != {CntW{1'b1}}) drop_cnt_q <= drop_cnt_q + CntW'(1);
      end
   end

   assign drop_cnt_o = drop_cnt_q;
   assign ovf_o      = ovf_q;

   depth_param_ok: assert property (@(posedge clk_i) Depth >= 1);

   depth_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
      depth_o <= DepthFull);

   full_implies_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !under_rst_q |-> !(full_o && !rvalid_o));

   outputs_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !$isunknown({wready_o, rvalid_o, rdata_o, full_o, depth_o, almost_full_o,
                   almost_empty_o, af_rise_o, drop_cnt_o, ovf_o}));

endmodule

// File: tb/tb_prim_fifo_sync_wm.sv
// tb/tb_prim_fifo_sync_wm.sv - directed self-checking bench for prim_fifo_sync_wm

module tb_prim_fifo_sync_wm;

   logic       clk = 1'b0;
   logic       rst_n, clr, wvalid, rready;
   logic [7:0] wdata;
   logic [2:0] af_th, ae_th;
   logic [0:0] af_th1, ae_th1;

   logic       wready, rvalid, full, af, ae, rise, ovf;
   logic [7:0] rdata;
   logic [2:0] depth;
   logic [3:0] drop;

   logic       wready_np, rvalid_np, full_np, af_np, ae_np, rise_np, ovf_np;
   logic [7:0] rdata_np;
   logic [2:0] depth_np;
   logic [3:0] drop_np;

   logic       wready1, rvalid1, full1, af1, ae1, rise1, ovf1;
   logic [7:0] rdata1;
   logic [0:0] depth1;
   logic [3:0] drop1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   prim_fifo_sync_wm #(.Width(8), .Depth(5), .Pass(1'b1), .OutputZeroIfEmpty(1'b1), .CntW(4)) dut (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
      .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata),
      .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata),
      .full_o(full), .depth_o(depth), .af_thresh_i(af_th), .ae_thresh_i(ae_th),
      .almost_full_o(af), .almost_empty_o(ae), .af_rise_o(rise),
      .drop_cnt_o(drop), .ovf_o(ovf)
   );

   prim_fifo_sync_wm #(.Width(8), .Depth(5), .Pass(1'b0), .OutputZeroIfEmpty(1'b1), .CntW(4)) dut_np (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
      .wvalid_i(wvalid), .wready_o(wready_np), .wdata_i(wdata),
      .rvalid_o(rvalid_np), .rready_i(rready), .rdata_o(rdata_np),
      .full_o(full_np), .depth_o(depth_np), .af_thresh_i(af_th), .ae_thresh_i(ae_th),
      .almost_full_o(af_np), .almost_empty_o(ae_np), .af_rise_o(rise_np),
      .drop_cnt_o(drop_np), .ovf_o(ovf_np)
   );

   prim_fifo_sync_wm #(.Width(8), .Depth(1), .Pass(1'b1), .OutputZeroIfEmpty(1'b1), .CntW(4)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
      .wvalid_i(wvalid), .wready_o(wready1), .wdata_i(wdata),
      .rvalid_o(rvalid1), .rready_i(rready), .rdata_o(rdata1),
      .full_o(full1), .depth_o(depth1), .af_thresh_i(af_th1), .ae_thresh_i(ae_th1),
      .almost_full_o(af1), .almost_empty_o(ae1), .af_rise_o(rise1),
      .drop_cnt_o(drop1), .ovf_o(ovf1)
   );

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] vals [3];

      rst_n = 1'b0; clr = 1'b0; wvalid = 1'b1; wdata = 8'h11; rready = 1'b0;
      af_th = 3'd4; ae_th = 3'd1; af_th1 = 1'b1; ae_th1 = 1'b0;
      repeat (2) cyc();

      chk("rst_depth", depth, 0);
      chk("rst_ae", ae, 1);
      chk("rst_af", af, 0);
      chk("rst_full", full, 0);
      chk("rst_drop", drop, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rdata", rdata, 0);

      rst_n = 1'b1;
      #1;
      chk("first_cycle_wready", wready, 0);
      cyc();

      for (int k = 1; k <= 5; k++) begin
         wdata = 8'(17 * k);
         #1;
         chk("fill_depth", depth, k - 1);
         chk("fill_wready", wready, 1);
         chk("fill_af", af, (k - 1) >= 4);
         chk("fill_rise", rise, (k - 1) == 4);
         chk("fill_ae", ae, (k - 1) <= 1);
         if (k == 1) begin
            chk("pass_rvalid_fill", rvalid, 1);
            chk("pass_rdata_fill", rdata, 8'h11);
         end
         cyc();
      end
      wvalid = 1'b0;
      #1;
      chk("full_depth", depth, 5);
      chk("full_flag", full, 1);
      chk("full_af", af, 1);
      chk("full_rise_once", rise, 0);
      chk("full_wready", wready, 0);
      chk("full_drop", drop, 0);

      rready = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         #1;
         chk("read_rvalid", rvalid, 1);
         chk("read_data", rdata, 8'(17 * k));
         cyc();
      end
      rready = 1'b0;
      #1;
      chk("drain_depth", depth, 0);
      chk("drain_rvalid", rvalid, 0);
      chk("drain_rdata", rdata, 0);
      chk("drain_ae", ae, 1);
      chk("drain_af", af, 0);

      wvalid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wdata = 8'(8'h60 + k);
         cyc();
      end
      chk("ovf_full", full, 1);
      chk("ovf_pre_drop", drop, 0);
      repeat (3) cyc();
      chk("drop_3", drop, 3);
      chk("ovf_set", ovf, 1);
      repeat (17) cyc();
      chk("drop_sat", drop, 15);
      chk("drop_depth", depth, 5);
      clr = 1'b1;
      cyc();
      clr = 1'b0; wvalid = 1'b0;
      #1;
      chk("clr_depth", depth, 0);
      chk("clr_drop", drop, 0);
      chk("clr_ovf", ovf, 0);
      chk("clr_full", full, 0);
      chk("clr_ae", ae, 1);
      chk("clr_af", af, 0);

      wvalid = 1'b1; rready = 1'b1; wdata = 8'hA5;
      #1;
      chk("pass_rvalid", rvalid, 1);
      chk("pass_rdata", rdata, 8'hA5);
      chk("nopass_rvalid", rvalid_np, 0);
      chk("nopass_rdata", rdata_np, 0);
      cyc();
      wvalid = 1'b0; rready = 1'b0;
      #1;
      chk("pass_depth", depth, 0);
      chk("nopass_depth", depth_np, 1);
      clr = 1'b1;
      cyc();
      clr = 1'b0;

      wvalid = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         wdata = 8'(8'hB0 + k);
         cyc();
      end
      wdata = 8'hC6; rready = 1'b1;
      #1;
      chk("fullrw_rdata", rdata, 8'hB1);
      chk("fullrw_wready", wready, 0);
      chk("fullrw_rvalid", rvalid, 1);
      cyc();
      wvalid = 1'b0; rready = 1'b0;
      #1;
      chk("fullrw_depth", depth, 4);
      chk("fullrw_drop", drop, 1);
      chk("fullrw_full", full, 0);
      chk("fullrw_ovf", ovf, 1);
      rready = 1'b1;
      #1;
      chk("fullrw_next", rdata, 8'hB2);
      cyc();
      rready = 1'b0;
      #1;
      chk("pre_rst_depth", depth, 3);

      rst_n = 1'b0;
      #1;
      chk("async_depth", depth, 0);
      chk("async_ae", ae, 1);
      chk("async_af", af, 0);
      chk("async_drop", drop, 0);
      chk("async_ovf", ovf, 0);
      chk("async_rvalid", rvalid, 0);
      cyc();
      rst_n = 1'b1;
      cyc();

      vals[0] = 8'h31; vals[1] = 8'h42; vals[2] = 8'h53;
      for (int i = 0; i < 3; i++) begin
         wdata = vals[i]; wvalid = 1'b1; rready = 1'b0;
         cyc();
         wvalid = 1'b0;
         #1;
         chk("d1_depth", depth1, 1);
         chk("d1_full", full1, 1);
         chk("d1_af", af1, 1);
         chk("d1_wready", wready1, 0);
         chk("d1_rdata", rdata1, vals[i]);
         rready = 1'b1;
         cyc();
         rready = 1'b0;
         #1;
         chk("d1_empty", depth1, 0);
         chk("d1_ae", ae1, 1);
         chk("d1_rvalid", rvalid1, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
